// File: rtl/utemporal_mul_gen.sv
// Unary temporal multiplier operand generator: latches a signed input/weight pair and
// streams |i|*|w| as a unary bitstream over a 2^(WIDTH-1)-cycle enabled window.
module utemporal_mul_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] ival,
  input  logic [WIDTH-1:0] wval,
  output logic             prod_bit,
  output logic             sign_i,
  output logic             sign_w,
  output logic             mac_done,
  output logic             en_o
);
  localparam int M = WIDTH - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   cnt_q, cnt_d;
  logic [M:0]     mag_i_q, mag_i_d;
  logic [M:0]     mag_w_q, mag_w_d;
  logic           sgn_i_q, sgn_i_d;
  logic           sgn_w_q, sgn_w_d;
  logic           prod_bit_q, prod_bit_d;
  logic           sign_i_q, sign_i_d;
  logic           sign_w_q, sign_w_d;
  logic           mac_done_q, mac_done_d;
  logic           en_o_q, en_o_d;

  logic [M-1:0]   cnt_rev;
  logic           last;
  logic           load;

  // Magnitude fits in M+1 bits, so the most negative operand maps to 2^M.
  function automatic logic [M:0] mag_of(input logic [WIDTH-1:0] x);
    mag_of = x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  always_comb begin
    cnt_rev = '0;
    for (int unsigned b = 0; b < M; b++) begin
      cnt_rev[b] = cnt_q[M-1-b];
    end
  end

  assign last  = (cnt_q == '1);
  assign ready = (state_q == IDLE) | ((state_q == RUN) & en & last);
  // ready already encodes both the idle accept and the last-cycle back-to-back accept.
  assign load  = start & ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_i_d    = mag_i_q;
    mag_w_d    = mag_w_q;
    sgn_i_d    = sgn_i_q;
    sgn_w_d    = sgn_w_q;
    prod_bit_d = 1'b0;
    mac_done_d = 1'b0;
    en_o_d     = 1'b0;
    sign_i_d   = sign_i_q;
    sign_w_d   = sign_w_q;

    if (clr) begin
      state_d  = IDLE;
      cnt_d    = '0;
      mag_i_d  = '0;
      mag_w_d  = '0;
      sgn_i_d  = 1'b0;
      sgn_w_d  = 1'b0;
      sign_i_d = 1'b0;
      sign_w_d = 1'b0;
    end else begin
      if ((state_q == RUN) && en) begin
        prod_bit_d = ({1'b0, cnt_q} < mag_i_q) & (mag_w_q > {1'b0, cnt_rev});
        mac_done_d = (cnt_q == '0);
        en_o_d     = 1'b1;
        sign_i_d   = sgn_i_q;
        sign_w_d   = sgn_w_q;
        cnt_d      = cnt_q + 1'b1;
        if (last) begin
          state_d = IDLE;
        end
      end
      if (load) begin
        state_d = RUN;
        cnt_d   = '0;
        mag_i_d = mag_of(ival);
        mag_w_d = mag_of(wval);
        sgn_i_d = ival[WIDTH-1];
        sgn_w_d = wval[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_i_q    <= '0;
      mag_w_q    <= '0;
      sgn_i_q    <= 1'b0;
      sgn_w_q    <= 1'b0;
      prod_bit_q <= 1'b0;
      sign_i_q   <= 1'b0;
      sign_w_q   <= 1'b0;
      mac_done_q <= 1'b0;
      en_o_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_i_q    <= mag_i_d;
      mag_w_q    <= mag_w_d;
      sgn_i_q    <= sgn_i_d;
      sgn_w_q    <= sgn_w_d;
      prod_bit_q <= prod_bit_d;
      sign_i_q   <= sign_i_d;
      sign_w_q   <= sign_w_d;
      mac_done_q <= mac_done_d;
      en_o_q     <= en_o_d;
    end
  end

  assign prod_bit = prod_bit_q;
  assign sign_i   = sign_i_q;
  assign sign_w   = sign_w_q;
  assign mac_done = mac_done_q;
  assign en_o     = en_o_q;

endmodule

// File: tb/tb_utemporal_mul_gen.sv
// Bench for utemporal_mul_gen: window-level reference model checked every cycle,
// plus literal per-window ones/pulse counts.
module tb_utemporal_mul_gen;
  localparam int WIDTH = 8;
  localparam int M     = WIDTH - 1;
  localparam int L     = 1 << M;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             en    = 1'b0;
  logic             clr   = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] ival  = '0;
  logic [WIDTH-1:0] wval  = '0;
  logic             ready, prod_bit, sign_i, sign_w, mac_done, en_o;

  utemporal_mul_gen #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .start(start), .ready(ready),
    .ival(ival), .wval(wval), .prod_bit(prod_bit), .sign_i(sign_i), .sign_w(sign_w),
    .mac_done(mac_done), .en_o(en_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rev_m(input int k);
    int r = 0;
    for (int b = 0; b < M; b++) r |= ((k >> b) & 1) << (M - 1 - b);
    return r;
  endfunction

  function automatic int mag(input logic [WIDTH-1:0] x);
    int v = int'($signed(x));
    return (v < 0) ? -v : v;
  endfunction

  // Reference model state
  bit m_busy;
  int m_k, m_mi, m_mw;
  bit m_si_l, m_sw_l;
  bit e_prod, e_si, e_sw, e_mac, e_en;
  int tot_en = 0, tot_ones = 0, tot_mac = 0, last_one_at = -1;

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_mi = 0; m_mw = 0; m_si_l = 0; m_sw_l = 0;
    e_prod = 0; e_si = 0; e_sw = 0; e_mac = 0; e_en = 0;
  endtask

  task automatic cmp_outputs();
    chk("prod_bit", prod_bit, e_prod);
    chk("sign_i",   sign_i,   e_si);
    chk("sign_w",   sign_w,   e_sw);
    chk("mac_done", mac_done, e_mac);
    chk("en_o",     en_o,     e_en);
  endtask

  // Compare process
  initial begin
    bit acc;
    model_reset();
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        model_reset();
        cmp_outputs();
      end
      chk("ready", ready, int'(!m_busy || (en && m_k == L - 1)));
      @(posedge clk);
      if (rst_n) begin
        if (clr) begin
          model_reset();
        end else begin
          acc = start && (!m_busy || (en && m_k == L - 1));
          e_prod = 0; e_mac = 0; e_en = 0;
          if (m_busy && en) begin
            e_en   = 1;
            e_mac  = (m_k == 0);
            e_prod = (m_k < m_mi) && (rev_m(m_k) < m_mw);
            e_si   = m_si_l;
            e_sw   = m_sw_l;
            m_k++;
            if (m_k == L) begin
              m_busy = 0;
              m_k    = 0;
            end
          end
          if (acc) begin
            m_busy = 1; m_k = 0;
            m_mi = mag(ival); m_mw = mag(wval);
            m_si_l = ival[WIDTH-1]; m_sw_l = wval[WIDTH-1];
          end
        end
      end
      #1;
      cmp_outputs();
      if (en_o) begin
        if (prod_bit) begin
          tot_ones++;
          last_one_at = tot_en;
        end
        if (mac_done) tot_mac++;
        tot_en++;
      end
    end
  end

  // Stimulus
  int b_en, b_ones, b_mac;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_en = tot_en; b_ones = tot_ones; b_mac = tot_mac;
  endtask

  task automatic launch(input logic [WIDTH-1:0] i, input logic [WIDTH-1:0] w);
    int t = 0;
    ival = i; wval = w; start = 1'b1;
    #3;
    while (!ready && t < 400) begin
      @(negedge clk); #3;
      t++;
    end
    if (!ready) chk("launch_timeout", 0, 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // 64 x 64: rev(k) < 64 only for even k
    en = 1'b1;
    snap();
    launch(8'd64, 8'd64);
    cyc(135);
    chk("t1_ones", tot_ones - b_ones, 32);
    chk("t1_en_o", tot_en - b_en, 128);
    chk("t1_mac",  tot_mac - b_mac, 1);

    // -128 x 127: only k=127 has rev(k) = 127
    snap();
    launch(8'h80, 8'h7f);
    cyc(135);
    chk("t2_ones", tot_ones - b_ones, 127);
    chk("t2_sign_i", sign_i, 1);
    chk("t2_sign_w", sign_w, 0);

    // 37 x -128: ones exactly in cycles 0..36
    snap();
    launch(8'd37, 8'h80);
    cyc(135);
    chk("t3_ones", tot_ones - b_ones, 37);
    chk("t3_last_one", last_one_at - b_en, 36);
    chk("t3_sign_w", sign_w, 1);

    // Back-to-back with an ignored mid-window start
    snap();
    launch(8'd64, 8'd64);
    cyc(60);
    ival = 8'd5; wval = 8'd5; start = 1'b1;
    cyc(1);
    start = 1'b0;
    launch(8'h80, 8'h7f);
    cyc(135);
    chk("t4_en_o", tot_en - b_en, 256);
    chk("t4_mac",  tot_mac - b_mac, 2);
    chk("t4_ones", tot_ones - b_ones, 159);

    // Alternating enable
    snap();
    launch(8'd64, 8'd64);
    for (int c = 0; c < 280; c++) begin
      en = ~en;
      cyc(1);
    end
    en = 1'b1;
    cyc(5);
    chk("t5_ones", tot_ones - b_ones, 32);
    chk("t5_en_o", tot_en - b_en, 128);
    chk("t5_mac",  tot_mac - b_mac, 1);

    // clr mid-window, then async reset mid-window
    snap();
    launch(8'd64, 8'd64);
    cyc(49);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(3);
    chk("t6_ready_after_clr", ready, 1);
    chk("t6_en_o_after_clr", en_o, 0);
    chk("t6_sign_i_after_clr", sign_i, 0);
    chk("t6_mac", tot_mac - b_mac, 1);
    launch(8'd37, 8'h80);
    cyc(20);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    snap();
    cyc(20);
    chk("t6_mac_after_rst", tot_mac - b_mac, 0);
    chk("t6_en_after_rst", tot_en - b_en, 0);
    chk("t6_ready_after_rst", ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
